// File: rtl/pc_fetch_pkg.sv
// Shared rvseed defines for the fetch stage: datapath width, default reset PC,
// the 2-bit fetch state encoding and a small alignment helper.
package pc_fetch_pkg;

    localparam int          RV_CPU_WIDTH = 32;
    localparam logic [31:0] RV_RESET_PC  = 32'h8000_0000;

    // Fetch FSM encoding; the bench probes these values directly
    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    typedef enum logic [1:0] {
        FS_REQ   = ST_REQ,
        FS_WAIT  = ST_WAIT,
        FS_HOLD  = ST_HOLD,
        FS_FAULT = ST_FAULT
    } fetch_state_e;

    // Instruction fetches must be word aligned
    function automatic logic pc_aligned(input logic [1:0] pc_lsb);
        return (pc_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// rvseed instruction-fetch stage: owns the PC, issues one memory read per
// instruction and holds the fetched word for decode under valid/ready.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int                   CPU_WIDTH = RV_CPU_WIDTH,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = RV_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPU_WIDTH-1:0] next_pc,
    output logic                 pc_ena,
    output logic [CPU_WIDTH-1:0] curr_pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    input  logic                 imem_rsp_err,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [31:0]          inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    output logic                 fetch_fault
);

    fetch_state_e         state_r;
    fetch_state_e         state_nxt_s;
    logic [CPU_WIDTH-1:0] curr_pc_r;
    logic [31:0]          inst_r;
    logic                 fault_r;

    logic                 req_valid_s;
    logic                 inst_valid_s;
    logic                 pc_ena_s;
    logic                 capture_s;
    logic                 load_pc_s;

    // Next-state decode and per-state handshake outputs
    always_comb begin
        state_nxt_s  = state_r;
        req_valid_s  = 1'b0;
        inst_valid_s = 1'b0;
        pc_ena_s     = 1'b0;
        capture_s    = 1'b0;
        load_pc_s    = 1'b0;
        case (state_r)
            FS_REQ: begin
                // A misaligned PC never reaches the bus
                if (!pc_aligned(curr_pc_r[1:0])) begin
                    state_nxt_s = FS_FAULT;
                end else begin
                    req_valid_s = 1'b1;
                    if (imem_req_ready) begin
                        state_nxt_s = FS_WAIT;
                    end else begin
                        state_nxt_s = FS_REQ;
                    end
                end
            end
            FS_WAIT: begin
                if (imem_rsp_valid && imem_rsp_err) begin
                    state_nxt_s = FS_FAULT;
                end else if (imem_rsp_valid) begin
                    capture_s   = 1'b1;
                    state_nxt_s = FS_HOLD;
                end else begin
                    state_nxt_s = FS_WAIT;
                end
            end
            FS_HOLD: begin
                inst_valid_s = 1'b1;
                if (inst_ready) begin
                    pc_ena_s    = 1'b1;
                    load_pc_s   = 1'b1;
                    state_nxt_s = FS_REQ;
                end else begin
                    state_nxt_s = FS_HOLD;
                end
            end
            FS_FAULT: begin
                state_nxt_s = FS_FAULT;
            end
            default: begin
                state_nxt_s = FS_REQ;
            end
        endcase
    end

    // State, PC, held instruction and sticky fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= FS_REQ;
            curr_pc_r <= RESET_PC;
            inst_r    <= 32'h0000_0000;
            fault_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (load_pc_s) begin
                curr_pc_r <= next_pc;
            end
            if (capture_s) begin
                inst_r <= imem_rsp_data;
            end
            fault_r <= (state_nxt_s == FS_FAULT);
        end
    end

    // Valids and the mux enable are masked during reset so nothing leaks out
    // while the state register still holds a pre-reset value.
    assign imem_req_valid = req_valid_s & ~rst;
    assign inst_valid     = inst_valid_s & ~rst;
    assign pc_ena         = pc_ena_s & ~rst;

    assign curr_pc        = curr_pc_r;
    assign imem_req_addr  = curr_pc_r;
    assign inst_pc        = curr_pc_r;
    assign inst           = inst_r;
    assign fetch_fault    = fault_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a per-cycle vector table covering the main
// flows, plus a hand-written bounded fetch/decode-stall sequence.
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        pc_ena;
    logic [31:0] curr_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    pc_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .pc_ena         (pc_ena),
        .curr_pc        (curr_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic        rst;
        logic        rdy;
        logic        rv;
        logic        re;
        logic [31:0] rd;
        logic        ir;
        logic [31:0] npc;
        logic [1:0]  st;
        logic        rqv;
        logic        pce;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        flt;
    } vec_t;

    vec_t tbl[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   req_count = 0;

    localparam logic [31:0] P0 = 32'h8000_0000;
    localparam logic [31:0] P4 = 32'h8000_0004;
    localparam logic [31:0] PB = 32'h8000_0100;
    localparam logic [31:0] PM = 32'h8000_0102;
    localparam logic [31:0] I0 = 32'h0000_0013;
    localparam logic [31:0] I1 = 32'h0010_0093;

    // Accepted request handshakes
    always @(posedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) req_count <= req_count + 1;
    end

    task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s step %0d: got %h, want %h", name, step, act, exp);
        else pass_cnt++;
    endtask

    task automatic add(input logic chk, input logic r, input logic rdy, input logic rv, input logic re,
                       input logic [31:0] rd, input logic ir, input logic [31:0] npc, input logic [1:0] st,
                       input logic rqv, input logic pce, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic flt);
        vec_t v;
        v.chk = chk; v.rst = r; v.rdy = rdy; v.rv = rv; v.re = re; v.rd = rd; v.ir = ir; v.npc = npc;
        v.st = st; v.rqv = rqv; v.pce = pce; v.iv = iv; v.pc = pc; v.inst = ins; v.flt = flt;
        tbl.push_back(v);
    endtask

    initial begin
        int base_cnt;
        int waited;
        logic [1:0] st_now;
        base_cnt = 0;
        rst = 1'b1; next_pc = 32'h0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; imem_rsp_err = 1'b0; inst_ready = 1'b0;

        //  chk rst rdy rv re data          ir npc   state     rqv pce iv pc  inst flt
        add(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b0,1'b0,1'b0,P0,32'h0,1'b0); // 0
        add(1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b0,1'b0,1'b0,P0,32'h0,1'b0); // 1 reset
        add(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,P0,32'h0,1'b0); // 2 first req
        add(1'b1,1'b0,1'b0,1'b1,1'b0,I0,           1'b0,32'h0,ST_WAIT, 1'b0,1'b0,1'b0,P0,32'h0,1'b0); // 3 rsp
        add(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,P4,   ST_HOLD, 1'b0,1'b1,1'b1,P0,I0,   1'b0); // 4 handshake
        add(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,P4,I0,   1'b0); // 5 mem stall
        add(1'b1,1'b0,1'b0,1'b1,1'b0,32'hBAD0_BAD0,1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,P4,I0,   1'b0); // 6 stray rsp
        add(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,P4,I0,   1'b0); // 7
        add(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,P4,I0,   1'b0); // 8
        add(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,P4,I0,   1'b0); // 9 accept
        add(1'b1,1'b0,1'b0,1'b1,1'b0,I1,           1'b0,32'h0,ST_WAIT, 1'b0,1'b0,1'b0,P4,I0,   1'b0); // 10
        add(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_HOLD, 1'b0,1'b0,1'b1,P4,I1,   1'b0); // 11 decode stall
        add(1'b1,1'b0,1'b0,1'b1,1'b0,32'hDEAD_BEEF,1'b0,32'h0,ST_HOLD, 1'b0,1'b0,1'b1,P4,I1,   1'b0); // 12 stray rsp
        add(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_HOLD, 1'b0,1'b0,1'b1,P4,I1,   1'b0); // 13
        add(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,PB,   ST_HOLD, 1'b0,1'b1,1'b1,P4,I1,   1'b0); // 14 branch
        add(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,PB,I1,   1'b0); // 15
        add(1'b1,1'b0,1'b0,1'b1,1'b1,32'hCAFE_0000,1'b0,32'h0,ST_WAIT, 1'b0,1'b0,1'b0,PB,I1,   1'b0); // 16 bus err
        add(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0,ST_FAULT,1'b0,1'b0,1'b0,PB,I1,   1'b1); // 17
        add(1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0,ST_FAULT,1'b0,1'b0,1'b0,PB,I1,   1'b1); // 18
        add(1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_FAULT,1'b0,1'b0,1'b0,PB,I1,   1'b1); // 19 rst
        add(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,P0,32'h0,1'b0); // 20
        add(1'b1,1'b0,1'b0,1'b1,1'b0,I0,           1'b0,32'h0,ST_WAIT, 1'b0,1'b0,1'b0,P0,32'h0,1'b0); // 21
        add(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,PM,   ST_HOLD, 1'b0,1'b1,1'b1,P0,I0,   1'b0); // 22 misaligned
        add(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b0,1'b0,1'b0,PM,I0,   1'b0); // 23 no req
        add(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_FAULT,1'b0,1'b0,1'b0,PM,I0,   1'b1); // 24
        add(1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_FAULT,1'b0,1'b0,1'b0,PM,I0,   1'b1); // 25 rst
        add(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,P0,32'h0,1'b0); // 26
        add(1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_WAIT, 1'b0,1'b0,1'b0,P0,32'h0,1'b0); // 27 rst in WAIT
        add(1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b0,1'b0,1'b0,P0,32'h0,1'b0); // 28
        add(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,P0,32'h0,1'b0); // 29
        add(1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_1111,1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,P0,32'h0,1'b0); // 30 stray
        add(1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,ST_REQ,  1'b1,1'b0,1'b0,P0,32'h0,1'b0); // 31

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; imem_req_ready = tbl[i].rdy; imem_rsp_valid = tbl[i].rv;
            imem_rsp_err = tbl[i].re; imem_rsp_data = tbl[i].rd; inst_ready = tbl[i].ir;
            next_pc = tbl[i].npc;
            #1;
            if (i == 5 || i == 17) base_cnt = req_count;
            if (i == 15) check("reqs_during_stall", i, 32'(req_count - base_cnt), 32'd1);
            if (i == 19) check("reqs_in_fault", i, 32'(req_count - base_cnt), 32'd0);
            if (tbl[i].chk) begin
                st_now = dut.state_r;
                check("state", i, {30'd0, st_now}, {30'd0, tbl[i].st});
                check("req_valid", i, {31'd0, imem_req_valid}, {31'd0, tbl[i].rqv});
                check("pc_ena", i, {31'd0, pc_ena}, {31'd0, tbl[i].pce});
                check("inst_valid", i, {31'd0, inst_valid}, {31'd0, tbl[i].iv});
                check("curr_pc", i, curr_pc, tbl[i].pc);
                check("req_addr", i, imem_req_addr, tbl[i].pc);
                check("inst_pc", i, inst_pc, tbl[i].pc);
                check("inst", i, inst, tbl[i].inst);
                check("fetch_fault", i, {31'd0, fetch_fault}, {31'd0, tbl[i].flt});
            end
        end

        // Hand sequence: minimum-latency fetch, then a bounded wait for decode valid
        @(negedge clk);
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; inst_ready = 1'b0; imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0113;
        @(negedge clk);
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        waited = 0;
        while (!inst_valid && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        check("hold_latency", 100, 32'(waited), 32'd0);
        check("hold_inst", 100, inst, 32'h0050_0113);
        check("hold_pc_ena_idle", 100, {31'd0, pc_ena}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("hold_inst_stable", 101, inst, 32'h0050_0113);
        check("hold_inst_pc_stable", 101, inst_pc, P0);
        inst_ready = 1'b1; next_pc = P4;
        #1;
        check("hold_pc_ena", 102, {31'd0, pc_ena}, 32'd1);
        @(negedge clk);
        inst_ready = 1'b0; next_pc = 32'h0;
        #1;
        check("after_pc_ena", 103, {31'd0, pc_ena}, 32'd0);
        check("after_curr_pc", 103, curr_pc, P4);
        check("after_req_valid", 103, {31'd0, imem_req_valid}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
